// File: rtl/fifo_write_frontend_if.sv
// Handshake bundle between the DSP sample stream, the write front end and the FIFO write port.
// The master side is the environment (upstream source plus FIFO full flag); the slave side is the front end.
interface fifo_write_frontend_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  s_valid;
    logic                  s_ready;
    logic [DATA_WIDTH-1:0] s_data;
    logic                  full;
    logic                  w_en;
    logic [DATA_WIDTH-1:0] w_data;

    modport master (
        output s_valid,
        output s_data,
        output full,
        input  s_ready,
        input  w_en,
        input  w_data
    );

    modport slave (
        input  s_valid,
        input  s_data,
        input  full,
        output s_ready,
        output w_en,
        output w_data
    );
endinterface

// File: rtl/fifo_write_frontend.sv
// Write-domain front end of the async sample FIFO: two-entry skid buffer in front of the
// registered-full write port, with optional drop-on-overflow and saturating drop accounting.
module fifo_write_frontend #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 i_wclk,
    input  logic                 i_wrst,
    fifo_write_frontend_if.slave bus,
    input  logic                 i_drop_mode,
    input  logic                 i_ovf_clr,
    output logic [1:0]           o_level,
    output logic [CNT_WIDTH-1:0] o_ovf_count,
    output logic                 o_ovf_sticky
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t                r_state;
    logic                  r_wen;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_skid_data;
    logic [CNT_WIDTH-1:0]  r_ovf_count;
    logic                  r_ovf_sticky;

    logic w_in_fire;
    logic w_write_fire;
    logic w_drop;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + CNT_WIDTH'(1);
    endfunction

    // Ready only looks at registered occupancy so the full flag never reaches s_ready combinationally.
    assign bus.s_ready  = !i_wrst && ((r_state != ST_TWO) || i_drop_mode);
    assign w_in_fire    = bus.s_valid && bus.s_ready;
    assign w_write_fire = r_wen && !bus.full;
    assign w_drop       = (r_state == ST_TWO) && w_in_fire && !w_write_fire;

    assign bus.w_en     = r_wen;
    assign bus.w_data   = r_wdata;
    assign o_level      = r_state;
    assign o_ovf_count  = r_ovf_count;
    assign o_ovf_sticky = r_ovf_sticky;

    always_ff @(posedge i_wclk) begin
        if (i_wrst) begin
            r_state      <= ST_EMPTY;
            r_wen        <= 1'b0;
            r_wdata      <= '0;
            r_skid_data  <= '0;
            r_ovf_count  <= '0;
            r_ovf_sticky <= 1'b0;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_in_fire) begin
                        r_state <= ST_ONE;
                        r_wen   <= 1'b1;
                        r_wdata <= bus.s_data;
                    end
                end
                ST_ONE: begin
                    if (w_in_fire && w_write_fire) begin
                        r_wdata <= bus.s_data;
                    end else if (w_in_fire) begin
                        r_state     <= ST_TWO;
                        r_skid_data <= bus.s_data;
                    end else if (w_write_fire) begin
                        r_state <= ST_EMPTY;
                        r_wen   <= 1'b0;
                    end
                end
                ST_TWO: begin
                    // Accepting in TWO only happens in drop mode; without a write it is a drop.
                    if (w_write_fire) begin
                        r_wdata <= r_skid_data;
                        if (w_in_fire) begin
                            r_skid_data <= bus.s_data;
                        end else begin
                            r_state <= ST_ONE;
                        end
                    end
                end
                default: begin
                    r_state <= ST_EMPTY;
                    r_wen   <= 1'b0;
                end
            endcase

            // A clear coinciding with a drop still records that drop.
            if (i_ovf_clr) begin
                r_ovf_count  <= w_drop ? CNT_WIDTH'(1) : '0;
                r_ovf_sticky <= w_drop;
            end else if (w_drop) begin
                r_ovf_count  <= sat_inc(r_ovf_count);
                r_ovf_sticky <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fifo_write_frontend.sv
// Scoreboard bench for fifo_write_frontend: a word-count/queue reference model predicts acceptance,
// drops and write order; a separate monitor pops expected words on every FIFO write.
module tb_fifo_write_frontend;

    localparam int DW   = 32;
    localparam int CW   = 3;
    localparam int CMAX = (1 << CW) - 1;

    bit clk;
    logic rst;
    logic drop_mode;
    logic ovf_clr;
    logic [1:0] level;
    logic [CW-1:0] ovf_count;
    logic ovf_sticky;

    fifo_write_frontend_if #(.DATA_WIDTH(DW)) bus();

    fifo_write_frontend #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .i_wclk      (clk),
        .i_wrst      (rst),
        .bus         (bus),
        .i_drop_mode (drop_mode),
        .i_ovf_clr   (ovf_clr),
        .o_level     (level),
        .o_ovf_count (ovf_count),
        .o_ovf_sticky(ovf_sticky)
    );

    initial forever #5 clk = ~clk;

    int n_pass;
    int n_total;
    logic [DW-1:0] exp_q[$];

    int m_held;
    int m_cnt;
    bit m_sticky;
    bit m_zero = 1'b1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    endtask

    // Reference model: checks the state produced by the previous edge, then predicts the next edge.
    always @(negedge clk) begin
        bit exp_rdy, wf, fire, drop;
        exp_rdy = !rst && (m_held != 2 || drop_mode);
        chk("s_ready", 32'(bus.s_ready), 32'(exp_rdy));
        chk("level", 32'(level), 32'(m_held));
        chk("w_en", 32'(bus.w_en), 32'(m_held != 0));
        chk("ovf_count", 32'(ovf_count), 32'(m_cnt));
        chk("ovf_sticky", 32'(ovf_sticky), 32'(m_sticky));
        if (m_zero) chk("w_data_after_reset", bus.w_data, 32'h0);
        if (rst) begin
            m_held = 0;
            m_cnt = 0;
            m_sticky = 1'b0;
            m_zero = 1'b1;
            exp_q.delete();
        end else begin
            wf   = (m_held != 0) && !bus.full;
            fire = bus.s_valid && exp_rdy;
            drop = fire && (m_held == 2) && !wf;
            if (wf) m_held--;
            if (fire && !drop) begin
                exp_q.push_back(bus.s_data);
                m_held++;
                m_zero = 1'b0;
            end
            if (ovf_clr) begin
                m_cnt = drop ? 1 : 0;
                m_sticky = drop;
            end else if (drop) begin
                m_cnt = (m_cnt == CMAX) ? CMAX : m_cnt + 1;
                m_sticky = 1'b1;
            end
        end
    end

    // Monitor: every cycle that will be a FIFO write must carry the next expected word.
    always @(negedge clk) begin
        if (!rst && bus.w_en && !bus.full) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_write: got w_data=%0h, expected no write", bus.w_data);
            end else begin
                chk("w_data", bus.w_data, exp_q.pop_front());
            end
        end
    end

    task automatic step(input logic v, input logic [DW-1:0] d, input logic f,
                        input logic dm, input logic clr, input logic r);
        @(posedge clk);
        #1;
        bus.s_valid = v;
        bus.s_data  = d;
        bus.full    = f;
        drop_mode   = dm;
        ovf_clr     = clr;
        rst         = r;
    endtask

    initial begin
        int seq;
        logic dm;
        rst         = 1'b1;
        bus.s_valid = 1'b1;
        bus.s_data  = 32'h55;
        bus.full    = 1'b0;
        drop_mode   = 1'b0;
        ovf_clr     = 1'b0;

        repeat (3) step(1'b1, 32'h55, 1'b0, 1'b0, 1'b0, 1'b1);
        repeat (3) step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);

        for (int i = 1; i <= 8; i++) step(1'b1, DW'(i), 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Back-pressure: data held until accepted, full asserted for 5 cycles mid-stream.
        seq = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.s_valid && bus.s_ready) seq++;
            @(posedge clk);
            #1;
            bus.s_valid = 1'b1;
            bus.s_data  = 32'h100 + DW'(seq);
            bus.full    = (i >= 6 && i < 11);
        end
        repeat (4) step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);

        for (int v = 'hA; v <= 'hF; v++) step(1'b1, DW'(v), 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        chk("drop_count", 32'(ovf_count), 32'd4);
        chk("drop_sticky", 32'(ovf_sticky), 32'd1);
        chk("drop_level", 32'(level), 32'd2);

        step(1'b1, 32'h10, 1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        chk("clr_with_drop_count", 32'(ovf_count), 32'd1);
        chk("clr_with_drop_sticky", 32'(ovf_sticky), 32'd1);
        step(1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        chk("clr_alone_count", 32'(ovf_count), 32'd0);
        chk("clr_alone_sticky", 32'(ovf_sticky), 32'd0);
        repeat (4) step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);

        dm = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            if (i % 50 == 0) dm = 1'($urandom_range(0, 1));
            step(1'($urandom_range(0, 9) < 7), DW'($urandom), 1'($urandom_range(0, 3) == 0),
                 dm, 1'($urandom_range(0, 49) == 0), 1'b0);
        end

        step(1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b1, 32'h200 + DW'(i), 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        chk("sat_count", 32'(ovf_count), 32'(CMAX));
        chk("sat_level", 32'(level), 32'd2);

        step(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b1);
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("midrst_level", 32'(level), 32'd0);
        chk("midrst_w_en", 32'(bus.w_en), 32'd0);
        repeat (5) step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
